// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM encoding, word types, GF(2^8) helpers
// and the forward S-box table used by the SubWord block.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [31:0]          word_t;
  typedef logic [AES_NK*32-1:0] key_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

endpackage

// File: rtl/aes128_key_schedule_if.sv
// Round-key stream: start/key request from the host, valid/ready key
// stream back to the consumer, plus status.
interface aes128_key_schedule_if;
  import aes_pkg::*;

  logic       start;
  key_t       key_in;
  logic       rk_valid;
  logic       rk_ready;
  key_t       round_key;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;

  // Key-expansion engine side.
  modport master (
    input  start, key_in, rk_ready,
    output rk_valid, round_key, round_idx, busy, done
  );

  // Host / round-key consumer side.
  modport slave (
    output start, key_in, rk_ready,
    input  rk_valid, round_key, round_idx, busy, done
  );

endinterface

// File: rtl/aes128_key_schedule_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module aes128_key_schedule_subword
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
  end

endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: one round key per accepted handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs zero
// RUN   | presenting round key round_idx, advancing on rk_valid & rk_ready
module aes128_key_schedule
  import aes_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  aes128_key_schedule_if.master ks
);

  ks_state_t  state, state_nxt;
  key_t       key_reg;
  logic [7:0] rcon;
  logic [3:0] idx_reg;
  logic       done_reg;

  logic accept, advance, finish;
  logic handshake, last_round;

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, temp;
  word_t n0, n1, n2, n3;
  key_t  next_key;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes128_key_schedule_subword u_subword (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign temp     = sub_w3 ^ {rcon, 24'h0};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign handshake  = (state == RUN) && ks.rk_ready;
  assign last_round = (idx_reg == 4'(AES_NR));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (ks.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          if (last_round) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key, rcon and round counter; done is registered so it lands in the
  // cycle after the round-10 handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg  <= '0;
      rcon     <= 8'h01;
      idx_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        key_reg <= ks.key_in;
        rcon    <= 8'h01;
        idx_reg <= '0;
      end else if (advance) begin
        key_reg <= next_key;
        rcon    <= xtime(rcon);
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

  // Outputs decoded from state; key and index are masked outside RUN.
  assign ks.rk_valid  = (state == RUN);
  assign ks.busy      = (state == RUN);
  assign ks.round_key = (state == RUN) ? key_reg : '0;
  assign ks.round_idx = (state == RUN) ? idx_reg : '0;
  assign ks.done      = done_reg;

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Directed bench for the AES-128 key schedule using FIPS-197 vectors.
module tb_aes128_key_schedule;

  localparam int MAX_CYC = 200;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  logic clk;
  logic rst_n;

  aes128_key_schedule_if ks_if ();

  aes128_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [127:0] got_key [11];
  int           got_cyc [11];
  int hs_cnt, done_cnt, done_cyc, stall_err, idx_err, timing_err, viol;
  bit done_busy, timed_out;

  vec_t a1_tab [11];
  logic [127:0] a1_key;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an expansion at the current negedge and consumes keys until done.
  task automatic run_expansion(input logic [127:0] key, input bit rand_ready, input int poke_round);
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    bit           prev_stall;
    bit           fin;
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; stall_err = 0; idx_err = 0;
    done_busy = 1'b1; fin = 1'b0; prev_stall = 1'b0; prev_key = '0; prev_idx = '0;
    for (int k = 0; k < 11; k++) begin
      got_key[k] = '0;
      got_cyc[k] = -1;
    end
    ks_if.key_in = key;
    ks_if.start  = 1'b1;
    @(negedge clk);
    ks_if.key_in = ~key;
    for (int c = 1; c <= MAX_CYC && !fin; c++) begin
      ks_if.start = 1'b0;
      if (prev_stall && (ks_if.rk_valid !== 1'b1 || ks_if.round_key !== prev_key ||
                         ks_if.round_idx !== prev_idx))
        stall_err++;
      if (ks_if.done === 1'b1) begin
        done_cnt++;
        done_cyc  = c;
        done_busy = ks_if.busy;
        fin       = 1'b1;
      end else begin
        if (poke_round >= 0 && ks_if.rk_valid === 1'b1 && ks_if.round_idx == 4'(poke_round)) begin
          ks_if.start  = 1'b1;
          ks_if.key_in = '1;
        end
        ks_if.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ks_if.rk_valid === 1'b1 && ks_if.rk_ready) begin
          if (ks_if.round_idx <= 4'd10) begin
            got_key[ks_if.round_idx] = ks_if.round_key;
            got_cyc[ks_if.round_idx] = c;
          end else begin
            idx_err++;
          end
          hs_cnt++;
        end
        prev_stall = (ks_if.rk_valid === 1'b1) && !ks_if.rk_ready;
        prev_key   = ks_if.round_key;
        prev_idx   = ks_if.round_idx;
        @(negedge clk);
      end
    end
    ks_if.start = 1'b0;
    timed_out = !fin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a1_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_tab[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    a1_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    a1_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    a1_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    a1_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    a1_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    a1_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    a1_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    a1_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    a1_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    a1_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst_n = 1'b0;
    ks_if.start = 1'b0;
    ks_if.rk_ready = 1'b0;
    ks_if.key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", ks_if.rk_valid, 0);
    check("rst_busy",  ks_if.busy, 0);
    check("rst_done",  ks_if.done, 0);
    check("rst_idx",   ks_if.round_idx, 0);
    check("rst_key",   ks_if.round_key, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle with rk_ready high and no start.
    ks_if.rk_ready = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      if (ks_if.rk_valid !== 1'b0 || ks_if.busy !== 1'b0 || ks_if.done !== 1'b0 ||
          ks_if.round_key !== '0 || ks_if.round_idx !== '0)
        viol++;
      @(negedge clk);
    end
    check("idle_quiet", viol, 0);

    // FIPS-197 A.1 with rk_ready held high.
    run_expansion(a1_key, 1'b0, -1);
    check("a1_timeout", timed_out, 0);
    timing_err = 0;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("a1_round%0d", a1_tab[k].idx), got_key[a1_tab[k].idx], a1_tab[k].key);
      if (got_cyc[k] != 1 + k) timing_err++;
    end
    check("a1_round_timing", timing_err, 0);
    check("a1_done_cycle", done_cyc, 12);
    check("a1_done_busy", done_busy, 0);
    check("a1_handshakes", hs_cnt, 11);
    check("a1_idx_range", idx_err, 0);
    @(negedge clk);
    check("a1_done_pulse_len", ks_if.done, 0);
    check("a1_idle_after", ks_if.rk_valid, 0);

    // Backpressure with a start poke (all-ones key) during round 4.
    run_expansion(a1_key, 1'b1, 4);
    check("bp_timeout", timed_out, 0);
    for (int k = 0; k < 11; k++)
      check($sformatf("bp_round%0d", a1_tab[k].idx), got_key[a1_tab[k].idx], a1_tab[k].key);
    check("bp_handshakes", hs_cnt, 11);
    check("bp_done_count", done_cnt, 1);
    check("bp_stall_stable", stall_err, 0);
    check("bp_idx_range", idx_err, 0);
    @(negedge clk);
    check("bp_done_pulse_len", ks_if.done, 0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_expansion(a1_key, 1'b0, -1);
    check("b2b_first_timeout", timed_out, 0);
    run_expansion('0, 1'b0, -1);
    check("b2b_timeout", timed_out, 0);
    check("b2b_round0", got_key[0], 128'h0);
    check("b2b_round1", got_key[1], 128'h62636363626363636263636362636363);
    check("b2b_round2", got_key[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    check("b2b_round10", got_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("b2b_round0_cycle", got_cyc[0], 1);
    check("b2b_done_cycle", done_cyc, 12);

    // Mid-run reset during round 6.
    @(negedge clk);
    ks_if.key_in = a1_key;
    ks_if.start = 1'b1;
    ks_if.rk_ready = 1'b1;
    @(negedge clk);
    ks_if.start = 1'b0;
    viol = 1;
    for (int c = 0; c < 20 && viol != 0; c++) begin
      if (ks_if.rk_valid === 1'b1 && ks_if.round_idx == 4'd6) viol = 0;
      else @(negedge clk);
    end
    check("mr_reached_round6", viol, 0);
    check("mr_round6_key", ks_if.round_key, a1_tab[6].key);
    rst_n = 1'b0;
    #1;
    check("mr_valid", ks_if.rk_valid, 0);
    check("mr_busy", ks_if.busy, 0);
    check("mr_idx", ks_if.round_idx, 0);
    check("mr_key", ks_if.round_key, 0);
    viol = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ks_if.done !== 1'b0) viol++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ks_if.done !== 1'b0 || ks_if.rk_valid !== 1'b0) viol++;
    end
    check("mr_no_done", viol, 0);
    run_expansion(a1_key, 1'b0, -1);
    check("mr_restart_timeout", timed_out, 0);
    check("mr_restart_round0", got_key[0], a1_tab[0].key);
    check("mr_restart_round10", got_key[10], a1_tab[10].key);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
